// File: rtl/lsu_mem_ctrl_if.sv
// Request / response / memory bus bundle for the load/store unit.
// slave: the LSU itself. master: the core execute stage plus the memory.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rw, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rw, mem_wr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one byte-addressed request at a time, checked for
// alignment/region, turned into word accesses (read-modify-write for
// sub-word stores) with extracted and extended load data.
module lsu_mem_ctrl #(
  parameter logic [15:0] DATA_BASE   = 16'h0800,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned IDX_W       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;   // store data on accept, merged word after RWAIT
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_addr;

  assign unused_addr = ^addr_q[15:IDX_W+2];

  // Legality of the incoming request: funct3, alignment, region and index.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = bus.req_addr[0];
      3'b010:         req_err = (bus.req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (bus.req_we && bus.req_funct3[2])
      req_err = 1'b1;
    if (bus.req_addr[31:16] != DATA_BASE)
      req_err = 1'b1;
    if (32'(bus.req_addr[IDX_W+1:2]) >= DEPTH_WORDS)
      req_err = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_v   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext = bus.mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_ext = {24'h000000, byte_v};
      3'b001:  load_ext = {{16{half_v[15]}}, half_v};
      3'b101:  load_ext = {16'h0000, half_v};
      default: load_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (f3_q[1:0] == 2'b01)
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged = wdata_q;
  end

  // Next-state selection; SW skips the read, sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_d = RESP;
          else if (bus.req_we && bus.req_funct3[1:0] == 2'b10)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:      state_d = RWAIT;
      RWAIT:   state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Request latch and response/write-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
          end
        end
        RWAIT: begin
          if (we_q)
            wdata_q <= merged;
          else
            rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_rw    = (state_q == RD);
  assign bus.mem_wr    = (state_q == WR);
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = {addr_q[31:16], 16'(addr_q[IDX_W+1:2])};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: the driver pushes expectations from a
// word-array reference model, a monitor pops and compares on responses.
module tb_lsu_mem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned nrw;
    int unsigned nwr;
    logic [31:0] maddr;
    logic [31:0] wword;
    int unsigned acc;
    int unsigned stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_rw = 0;
  int unsigned n_wr = 0;
  logic [31:0] phys [128];
  logic [31:0] ref_mem [128];
  exp_t        q [$];

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(
    .DATA_BASE  (16'h0800),
    .DEPTH_WORDS(128),
    .IDX_W      (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with registered read data.
  always @(posedge clk) begin
    if (bus.mem_rw) bus.mem_rdata <= phys[bus.mem_addr[6:0]];
    if (bus.mem_wr) phys[bus.mem_addr[6:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on a word array.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int unsigned idx, sz, sh;
    logic bad;
    logic [31:0] w;
    longint s;
    longint unsigned mask, nw;
    e = '{default: 0};
    idx = 32'(a[13:2]);
    e.maddr = {a[31:16], 16'(a[13:2])};
    bad = (a[31:16] != 16'h0800) || (idx >= 128);
    case (f3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (a[0]) bad = 1'b1;
      3'b010:         if (a[1:0] != 2'b00) bad = 1'b1;
      default:        bad = 1'b1;
    endcase
    if (we && f3 > 3'b010) bad = 1'b1;
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    w  = ref_mem[idx];
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    sh = (sz == 1) ? 8 * a[1:0] : (sz == 2) ? 16 * a[1] : 0;
    if (!we) begin
      e.lat = 3;
      e.nrw = 1;
      if (sz == 4) begin
        e.rdata = w;
      end else begin
        s = longint'((w >> sh) & ((32'd1 << (8 * sz)) - 1));
        if (!f3[2] && s >= (longint'(1) << (8 * sz - 1))) s -= (longint'(1) << (8 * sz));
        e.rdata = s[31:0];
      end
    end else begin
      mask = ((64'd1 << (8 * sz)) - 1) << sh;
      nw   = ({32'd0, w} & ~mask) | (({32'd0, wd} << sh) & mask);
      e.wword = nw[31:0];
      ref_mem[idx] = nw[31:0];
      e.nwr = 1;
      e.nrw = (sz < 4) ? 1 : 0;
      e.lat = (sz < 4) ? 4 : 2;
    end
    return e;
  endfunction

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench stopped early");
  endtask

  task automatic wait_idle(input logic need_empty);
    int unsigned k = 0;
    while (!(bus.req_ready && (!need_empty || q.size() == 0)) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      errors++; checks++;
      $display("FAIL idle_timeout got=busy exp=idle at cycle %0d", cyc);
      finish_now();
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int unsigned stall, input logic noise);
    exp_t e;
    int unsigned k;
    @(negedge clk);
    wait_idle(1'b0);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    e = model(we, f3, a, wd);
    e.acc   = cyc;
    e.stall = stall;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (noise) begin
      k = 0;
      while (!bus.rsp_valid && k < 50) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = 32'h0800_0000 | 32'($urandom_range(0, 511));
        bus.req_wdata  = $urandom;
        @(negedge clk);
        k++;
      end
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rw, bus.mem_wr}),
        32'b10000);
    chk({nm, "_rdata"}, bus.rsp_rdata, 32'h0);
    chk({nm, "_maddr"}, bus.mem_addr, 32'h0);
    chk({nm, "_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // Monitor: strobe accounting, response checking, backpressure control.
  initial begin : monitor
    exp_t e;
    logic seen, hs, cap_err;
    logic [31:0] cap_rdata;
    int unsigned st;
    seen = 1'b0; hs = 1'b0; st = 0; cap_err = 1'b0; cap_rdata = '0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_rw = 0; n_wr = 0; seen = 1'b0; hs = 1'b0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (hs) begin
        e = q.pop_front();
        chk("rw_count", n_rw, e.nrw);
        chk("wr_count", n_wr, e.nwr);
        chk("idle_after_hs", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        n_rw = 0; n_wr = 0; hs = 1'b0; seen = 1'b0;
        bus.rsp_ready = 1'b0;
      end
      if (bus.mem_rw || bus.mem_wr)
        chk("rw_wr_exclusive", 32'(bus.mem_rw & bus.mem_wr), 32'h0);
      if (bus.mem_rw) begin
        n_rw++;
        if (q.size() > 0) chk("rd_addr", bus.mem_addr, q[0].maddr);
      end
      if (bus.mem_wr) begin
        n_wr++;
        if (q.size() > 0) begin
          chk("wr_addr", bus.mem_addr, q[0].maddr);
          chk("wr_data", bus.mem_wdata, q[0].wword);
        end
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp got=rsp_valid exp=none at cycle %0d", cyc);
        end else if (!seen) begin
          seen = 1'b1;
          e = q[0];
          chk("latency", cyc - e.acc, e.lat);
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          cap_rdata = bus.rsp_rdata;
          cap_err   = bus.rsp_err;
          st = e.stall;
        end else begin
          chk("stall_rdata", bus.rsp_rdata, cap_rdata);
          chk("stall_err", 32'(bus.rsp_err), 32'(cap_err));
          chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
        end
        if (seen) begin
          if (st == 0) begin
            bus.rsp_ready = 1'b1;
            hs = 1'b1;
          end else begin
            st--;
          end
        end
      end
    end
  end

  initial begin : driver
    int unsigned k;
    logic [31:0] v, a;
    logic [2:0] f3;
    logic we;
    logic [2:0] legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
    legal[3] = 3'b100; legal[4] = 3'b101;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      phys[i] = v;
      ref_mem[i] = v;
    end
    phys[0] = 32'h1171_9195; ref_mem[0] = 32'h1171_9195;
    phys[1] = 32'h1603_2976; ref_mem[1] = 32'h1603_2976;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Loads on word0.
    issue(1'b0, 3'b000, 32'h0800_0000, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b100, 32'h0800_0001, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b001, 32'h0800_0002, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b010, 32'h0800_0000, 32'h0, 0, 1'b0);
    // Byte store read-modify-write, then read back.
    issue(1'b1, 3'b000, 32'h0800_0005, 32'h0000_00AB, 0, 1'b0);
    issue(1'b0, 3'b010, 32'h0800_0004, 32'h0, 0, 1'b0);
    // Word store.
    issue(1'b1, 3'b010, 32'h0800_0008, 32'hDEAD_BEEF, 0, 1'b0);
    issue(1'b0, 3'b010, 32'h0800_0008, 32'h0, 0, 1'b0);
    // Error cases.
    issue(1'b0, 3'b010, 32'h0800_0002, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b001, 32'h0800_0001, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b010, 32'h0900_0000, 32'h0, 0, 1'b0);
    issue(1'b0, 3'b010, 32'h0800_0200, 32'h0, 0, 1'b0);
    issue(1'b1, 3'b100, 32'h0800_0010, 32'h55, 0, 1'b0);
    issue(1'b0, 3'b011, 32'h0800_0010, 32'h0, 0, 1'b0);
    // Backpressure on a byte load, then an immediate follow-up.
    issue(1'b0, 3'b000, 32'h0800_0000, 32'h0, 5, 1'b0);
    issue(1'b0, 3'b101, 32'h0800_0006, 32'h0, 0, 1'b0);

    // Reset while a sub-word store sits in RWAIT: memory must be untouched.
    @(negedge clk);
    wait_idle(1'b1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0800_000C; bus.req_wdata = 32'h0000_005A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    issue(1'b0, 3'b010, 32'h0800_000C, 32'h0, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 7) == 0) ? {16'($urandom), 16'h0000} : 32'h0800_0000;
      a  = a | 32'($urandom_range(0, 16'h021F));
      if ($urandom_range(0, 3) != 0 && f3[1:0] == 2'b10) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0 && f3[1:0] == 2'b01) a[0] = 1'b0;
      issue(we, f3, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    k = 0;
    while (q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
